audio_volume_ctrl: RTL and testbench

AUDIO_VOLUME_CTRL -- requirements
Module: audio_volume_ctrl

---
 rtl/audio_volume_ctrl.sv | 152 +++++++++++++++
 tb/tb_audio_volume_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/audio_volume_ctrl.sv
// -----------------------------------------------------------------------------
// audio_volume_ctrl
//   Stereo square-wave tone generator with a shared 8-level volume control.
//   Each channel divides clk by its half-period to produce a square wave whose
//   amplitude is volume * AMP_STEP. Mute, volume 0 and a zero half-period
//   (rest) all produce silence.
//
// Ports
//   clk            in   system clock, rising-edge active
//   rst            in   synchronous active-high reset
//   vol_up         in   one-cycle pulse, raise volume one step (saturates at 7)
//   vol_down       in   one-cycle pulse, lower volume one step (saturates at 0)
//   mute           in   level, 1 forces both samples to zero
//   half_period_l  in   left tone half-period in clk cycles, 0 = rest
//   half_period_r  in   right tone half-period in clk cycles, 0 = rest
//   audio_in_left  out  registered signed left sample
//   audio_in_right out  registered signed right sample
//   volume         out  current volume level 0..7
//   vol_led        out  volume bar graph
// -----------------------------------------------------------------------------
module audio_volume_ctrl #(
  parameter int unsigned VOL_RESET = 3,
  parameter int unsigned AMP_STEP  = 4096
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               vol_up,
  input  logic               vol_down,
  input  logic               mute,
  input  logic [21:0]        half_period_l,
  input  logic [21:0]        half_period_r,
  output logic signed [15:0] audio_in_left,
  output logic signed [15:0] audio_in_right,
  output logic [2:0]         volume,
  output logic [7:0]         vol_led
);

  localparam logic [2:0]  VOL_RESET_C = 3'(VOL_RESET);
  localparam logic [14:0] AMP_STEP_C  = 15'(AMP_STEP);

  // Bar graph for a volume level. The top level lights the whole bar so
  // full scale reads as all LEDs on.
  function automatic logic [7:0] vol_bar(input logic [2:0] v);
    logic [7:0] bar;
    case (v)
      3'd0:    bar = 8'h00;
      3'd1:    bar = 8'h01;
      3'd2:    bar = 8'h03;
      3'd3:    bar = 8'h07;
      3'd4:    bar = 8'h0F;
      3'd5:    bar = 8'h1F;
      3'd6:    bar = 8'h3F;
      3'd7:    bar = 8'hFF;
      default: bar = 8'h00;
    endcase
    return bar;
  endfunction

  logic [2:0]  volume_q, volume_d;
  logic [7:0]  vol_led_q, vol_led_d;
  logic [14:0] amp_s;

  logic [21:0] hp_s     [2];
  logic [21:0] cnt_q    [2];
  logic [21:0] cnt_d    [2];
  logic        phase_q  [2];
  logic        phase_d  [2];
  logic [15:0] sample_q [2];
  logic [15:0] sample_d [2];

  assign hp_s[0] = half_period_l;
  assign hp_s[1] = half_period_r;

  // Volume next state: saturating up/down; simultaneous pulses cancel.
  always_comb begin
    volume_d = volume_q;
    if (vol_up && !vol_down) begin
      if (volume_q != 3'd7) begin
        volume_d = volume_q + 3'd1;
      end else begin
        volume_d = volume_q;
      end
    end else if (vol_down && !vol_up) begin
      if (volume_q != 3'd0) begin
        volume_d = volume_q - 3'd1;
      end else begin
        volume_d = volume_q;
      end
    end else begin
      volume_d = volume_q;
    end
    // Bar is registered from the next volume so it tracks volume with no lag.
    vol_led_d = vol_bar(volume_d);
  end

  assign amp_s = AMP_STEP_C * {12'd0, volume_q};

  // Per-channel tone counters and sample selection.
  always_comb begin
    for (int ch = 0; ch < 2; ch++) begin
      cnt_d[ch]    = cnt_q[ch];
      phase_d[ch]  = phase_q[ch];
      sample_d[ch] = 16'd0;
      if (hp_s[ch] == 22'd0) begin
        cnt_d[ch]   = 22'd0;
        phase_d[ch] = 1'b0;
      end else if (cnt_q[ch] >= hp_s[ch] - 22'd1) begin
        // >= rather than == so a shortened half-period wraps at once
        // instead of running the counter round 2^22.
        cnt_d[ch]   = 22'd0;
        phase_d[ch] = ~phase_q[ch];
      end else begin
        cnt_d[ch]   = cnt_q[ch] + 22'd1;
        phase_d[ch] = phase_q[ch];
      end
      if (mute || (volume_q == 3'd0) || (hp_s[ch] == 22'd0)) begin
        sample_d[ch] = 16'd0;
      end else if (phase_q[ch]) begin
        sample_d[ch] = {1'b0, amp_s};
      end else begin
        sample_d[ch] = 16'd0 - {1'b0, amp_s};
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      volume_q  <= VOL_RESET_C;
      vol_led_q <= vol_bar(VOL_RESET_C);
      for (int ch = 0; ch < 2; ch++) begin
        cnt_q[ch]    <= 22'd0;
        phase_q[ch]  <= 1'b0;
        sample_q[ch] <= 16'd0;
      end
    end else begin
      volume_q  <= volume_d;
      vol_led_q <= vol_led_d;
      for (int ch = 0; ch < 2; ch++) begin
        cnt_q[ch]    <= cnt_d[ch];
        phase_q[ch]  <= phase_d[ch];
        sample_q[ch] <= sample_d[ch];
      end
    end
  end

  assign volume         = volume_q;
  assign vol_led        = vol_led_q;
  assign audio_in_left  = sample_q[0];
  assign audio_in_right = sample_q[1];

endmodule

// File: tb/tb_audio_volume_ctrl.sv
module tb_audio_volume_ctrl;

  logic               clk;
  logic               rst;
  logic               vol_up;
  logic               vol_down;
  logic               mute;
  logic [21:0]        half_period_l;
  logic [21:0]        half_period_r;
  logic signed [15:0] audio_in_left;
  logic signed [15:0] audio_in_right;
  logic [2:0]         volume;
  logic [7:0]         vol_led;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [15:0] exp;
  } exp_t;

  exp_t sb_q[$];

  audio_volume_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .vol_up         (vol_up),
    .vol_down       (vol_down),
    .mute           (mute),
    .half_period_l  (half_period_l),
    .half_period_r  (half_period_r),
    .audio_in_left  (audio_in_left),
    .audio_in_right (audio_in_right),
    .volume         (volume),
    .vol_led        (vol_led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input string tag, input logic [15:0] e);
    exp_t item;
    item.tag = tag;
    item.exp = e;
    sb_q.push_back(item);
  endtask

  task automatic pop_check(input logic [15:0] obs);
    exp_t item;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty observed=%h expected=<none>", obs);
    end else begin
      item = sb_q.pop_front();
      assert (obs === item.exp) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", item.tag, obs, item.exp);
      end
    end
  endtask

  task automatic pulse(input logic up, input logic dn);
    vol_up   = up;
    vol_down = dn;
    tick();
    vol_up   = 1'b0;
    vol_down = 1'b0;
  endtask

  // Square wave sample after edge k (k=1 is the first edge with the tone on).
  function automatic logic [15:0] tone(input int k, input int half, input int amp);
    logic [15:0] a;
    a = 16'(amp);
    return ((((k - 1) / half) % 2) == 1) ? a : (16'd0 - a);
  endfunction

  initial begin
    int exp_up[6];
    logic [15:0] e;
    exp_up = '{4, 5, 6, 7, 7, 7};

    rst = 1'b1; vol_up = 1'b0; vol_down = 1'b0; mute = 1'b0;
    half_period_l = 22'd0; half_period_r = 22'd0;

    // Reset state
    push_exp("rst_volume", 16'd3);
    push_exp("rst_led", 16'h0007);
    push_exp("rst_left", 16'h0000);
    push_exp("rst_right", 16'h0000);
    tick();
    pop_check({13'd0, volume});
    pop_check({8'd0, vol_led});
    pop_check(audio_in_left);
    pop_check(audio_in_right);
    rst = 1'b0;

    // Volume up to saturation
    for (int i = 0; i < 6; i++) begin
      push_exp("vol_up_step", 16'(exp_up[i]));
      pulse(1'b1, 1'b0);
      pop_check({13'd0, volume});
    end
    push_exp("led_full", 16'h00FF);
    pop_check({8'd0, vol_led});

    // Volume down to 1, then to 0 twice
    for (int i = 0; i < 6; i++) pulse(1'b0, 1'b1);
    push_exp("vol_down_to1", 16'd1);
    pop_check({13'd0, volume});
    push_exp("vol_down_0a", 16'd0);
    pulse(1'b0, 1'b1);
    pop_check({13'd0, volume});
    push_exp("vol_down_0b", 16'd0);
    pulse(1'b0, 1'b1);
    pop_check({13'd0, volume});
    push_exp("led_empty", 16'h0000);
    pop_check({8'd0, vol_led});

    // Volume 0 with a tone: left stays silent
    half_period_l = 22'd10;
    for (int k = 1; k <= 25; k++) begin
      push_exp("vol0_left", 16'h0000);
      tick();
      pop_check(audio_in_left);
    end
    half_period_l = 22'd0;
    tick();

    // Back to volume 3
    for (int i = 0; i < 3; i++) pulse(1'b1, 1'b0);
    push_exp("vol3", 16'd3);
    pop_check({13'd0, volume});

    // Tone at half-period 4, mute window with a volume change inside it
    half_period_l = 22'd4;
    for (int k = 1; k <= 30; k++) begin
      mute   = (k >= 17 && k <= 19);
      vol_up = (k == 18);
      if (mute) e = 16'h0000;
      else      e = tone(k, 4, (k >= 20) ? 16384 : 12288);
      push_exp("tone4_left", e);
      push_exp("tone4_right", 16'h0000);
      tick();
      pop_check(audio_in_left);
      pop_check(audio_in_right);
      if (k == 18) begin
        push_exp("vol_in_mute", 16'd4);
        pop_check({13'd0, volume});
      end
    end
    mute = 1'b0; vol_up = 1'b0;

    // Simultaneous up/down at volume 5
    push_exp("vol5", 16'd5);
    pulse(1'b1, 1'b0);
    pop_check({13'd0, volume});
    push_exp("vol_both", 16'd5);
    pulse(1'b1, 1'b1);
    pop_check({13'd0, volume});
    push_exp("led5", 16'h001F);
    pop_check({8'd0, vol_led});

    // Half-period shortened below the running count
    half_period_l = 22'd0;
    tick();
    half_period_l = 22'd100;
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (k == 1 || k == 60) begin
        push_exp("hp100_left", 16'hB000);
        pop_check(audio_in_left);
      end
    end
    half_period_l = 22'd20;
    for (int k = 61; k <= 83; k++) begin
      push_exp("hp_shrink_left", (k >= 62 && k <= 81) ? 16'h5000 : 16'hB000);
      tick();
      pop_check(audio_in_left);
    end

    // Independent channels
    half_period_l = 22'd0; half_period_r = 22'd0;
    tick();
    half_period_l = 22'd3; half_period_r = 22'd5;
    for (int k = 1; k <= 20; k++) begin
      push_exp("stereo_left", tone(k, 3, 20480));
      push_exp("stereo_right", tone(k, 5, 20480));
      tick();
      pop_check(audio_in_left);
      pop_check(audio_in_right);
    end

    // Reset mid-tone, overriding a volume pulse
    rst = 1'b1; vol_up = 1'b1;
    push_exp("midrst_left", 16'h0000);
    push_exp("midrst_right", 16'h0000);
    push_exp("midrst_volume", 16'd3);
    push_exp("midrst_led", 16'h0007);
    tick();
    pop_check(audio_in_left);
    pop_check(audio_in_right);
    pop_check({13'd0, volume});
    pop_check({8'd0, vol_led});
    rst = 1'b0; vol_up = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      push_exp("restart_left", tone(k, 3, 12288));
      push_exp("restart_right", tone(k, 5, 12288));
      tick();
      pop_check(audio_in_left);
      pop_check(audio_in_right);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
